// File: rtl/fpu_normalize_round_pkg.sv
// fpu_normalize_round_pkg: shared float types, format constants and FSM states
// for the normalize/round tail of the FPU.
`default_nettype none

package fpu_normalize_round_pkg;

  typedef enum logic [1:0] {
    FMT_HALF   = 2'd0,
    FMT_SINGLE = 2'd1,
    FMT_DOUBLE = 2'd2
  } float_type_t;

  typedef struct packed {
    logic        sign;
    logic [15:0] exponent;
    logic [63:0] mantissa;
  } denormalized_t;

  // Result word; the packed encoding sits LSB-aligned in value, upper bits zero.
  typedef struct packed {
    float_type_t ftype;
    logic [63:0] value;
  } float_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } fpu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } norm_state_t;

  function automatic int frac_w(input float_type_t f);
    case (f)
      FMT_HALF:   return 10;
      FMT_SINGLE: return 23;
      default:    return 52;
    endcase
  endfunction

  function automatic logic signed [17:0] exp_max(input float_type_t f);
    case (f)
      FMT_HALF:   return 18'sd31;
      FMT_SINGLE: return 18'sd255;
      default:    return 18'sd2047;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_lzc64.sv
// fpu_lzc64: combinational leading-zero count of a 63-bit vector (63 when all zero).
`default_nettype none

module fpu_lzc64 (
  input  logic [62:0] i_data,
  output logic [5:0]  o_count
);

  always_comb begin
    o_count = 6'd63;
    // Ascending scan: the last hit is the most significant set bit.
    for (int i = 0; i < 63; i++) begin
      if (i_data[i]) o_count = 6'(62 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpu_normalize_round.sv
// fpu_normalize_round: renormalizes a wide mantissa, rounds to nearest-even and
// packs the result as half/single/double with overflow/underflow/inexact flags.
`default_nettype none

module fpu_normalize_round
  import fpu_normalize_round_pkg::*;
#(
  parameter int SHIFT_STEP = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$bits(denormalized_t)-1:0] fltIn,
  input  logic [$bits(float_type_t)-1:0]   fmt,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$bits(float_t)-1:0]     fltOut,
  output logic [2:0]                    flags
);

  norm_state_t        r_state, w_state_nxt;
  logic               r_sign;
  logic signed [17:0] r_exp;
  logic [63:0]        r_mant;
  float_type_t        r_fmt;
  logic               r_sticky;
  float_t             r_flt_out;
  fpu_flags_t         r_flags;

  denormalized_t      w_in;
  logic [5:0]         w_lz;
  logic [5:0]         w_shift;
  logic               w_mant_zero;

  assign w_in        = denormalized_t'(fltIn);
  assign w_mant_zero = (r_mant == 64'd0);

  fpu_lzc64 u_lzc (
    .i_data  (r_mant[62:0]),
    .o_count (w_lz)
  );

  assign w_shift = (int'(w_lz) > SHIFT_STEP) ? 6'(SHIFT_STEP) : w_lz;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid) w_state_nxt = ST_NORM;
      ST_NORM:  if (w_mant_zero || r_mant[63] || r_mant[62]) w_state_nxt = ST_ROUND;
      ST_ROUND: w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Rounding and packing from the normalized mantissa (hidden 1 at bit 62).
  logic [51:0]        w_frac, w_frac_rnd, w_mask, w_res_frac;
  logic               w_lsb, w_guard, w_rest, w_sticky_all, w_up, w_inexact;
  logic signed [17:0] w_exp_rnd, w_emax;
  logic [10:0]        w_res_exp;
  fpu_flags_t         w_res_flags;
  float_t             w_result;

  always_comb begin
    w_frac  = '0;
    w_lsb   = 1'b0;
    w_guard = 1'b0;
    w_rest  = 1'b0;
    case (r_fmt)
      FMT_HALF: begin
        w_frac  = 52'(r_mant[61:52]);
        w_lsb   = r_mant[52];
        w_guard = r_mant[51];
        w_rest  = |r_mant[50:0];
      end
      FMT_SINGLE: begin
        w_frac  = 52'(r_mant[61:39]);
        w_lsb   = r_mant[39];
        w_guard = r_mant[38];
        w_rest  = |r_mant[37:0];
      end
      default: begin
        w_frac  = r_mant[61:10];
        w_lsb   = r_mant[10];
        w_guard = r_mant[9];
        w_rest  = |r_mant[8:0];
      end
    endcase

    w_mask       = (52'd1 << frac_w(r_fmt)) - 52'd1;
    w_sticky_all = r_sticky | w_rest;
    w_up         = w_guard & (w_sticky_all | w_lsb);
    w_inexact    = w_guard | w_sticky_all;
    w_emax       = exp_max(r_fmt);

    if (w_up && (w_frac == w_mask)) begin
      w_frac_rnd = '0;
      w_exp_rnd  = r_exp + 18'sd1;
    end else begin
      w_frac_rnd = w_frac + 52'(w_up);
      w_exp_rnd  = r_exp;
    end

    w_res_flags = '0;
    w_res_exp   = w_exp_rnd[10:0];
    w_res_frac  = w_frac_rnd;
    if (w_mant_zero) begin
      w_res_exp  = '0;
      w_res_frac = '0;
    end else if (w_exp_rnd >= w_emax) begin
      w_res_exp             = w_emax[10:0];
      w_res_frac            = '0;
      w_res_flags.overflow  = 1'b1;
      w_res_flags.inexact   = 1'b1;
    end else if (w_exp_rnd <= 18'sd0) begin
      w_res_exp             = '0;
      w_res_frac            = '0;
      w_res_flags.underflow = 1'b1;
      w_res_flags.inexact   = 1'b1;
    end else begin
      w_res_flags.inexact   = w_inexact;
    end

    w_result.ftype = r_fmt;
    case (r_fmt)
      FMT_HALF:   w_result.value = 64'({r_sign, w_res_exp[4:0], w_res_frac[9:0]});
      FMT_SINGLE: w_result.value = 64'({r_sign, w_res_exp[7:0], w_res_frac[22:0]});
      default:    w_result.value = {r_sign, w_res_exp, w_res_frac};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_mant    <= '0;
      r_fmt     <= FMT_HALF;
      r_sticky  <= 1'b0;
      r_flt_out <= '0;
      r_flags   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign   <= w_in.sign;
            r_exp    <= 18'($unsigned(w_in.exponent));
            r_mant   <= w_in.mantissa;
            r_fmt    <= float_type_t'(fmt);
            r_sticky <= 1'b0;
          end
        end
        ST_NORM: begin
          if (w_mant_zero) begin
            r_mant <= r_mant;
          end else if (r_mant[63]) begin
            r_mant   <= r_mant >> 1;
            r_sticky <= r_sticky | r_mant[0];
            r_exp    <= r_exp + 18'sd1;
          end else if (!r_mant[62]) begin
            r_mant <= r_mant << w_shift;
            r_exp  <= r_exp - 18'(w_shift);
          end
        end
        ST_ROUND: begin
          r_flt_out <= w_result;
          r_flags   <= w_res_flags;
        end
        default: ;
      endcase
    end
  end

  // in_ready is masked during reset so it only rises once reset is released.
  assign in_ready  = (r_state == ST_IDLE) && !reset;
  assign out_valid = (r_state == ST_DONE);
  assign fltOut    = r_flt_out;
  assign flags     = r_flags;

endmodule

`default_nettype wire
